sample_readout_arbiter: RTL and testbench

- Schedules readout of the shared ADC sample buffer on the DCFEB by issuing the ready strobe to the sample-transfer engine.
- Tracks the number of L1A-matched events stored in the buffer.
- Arbitrates the single transfer engine between the DAQ (trigger) path and the JTAG slow-control path.
- Supervises each transfer with a watchdog; sits between L1A matching logic and the transfer FSM.

---
 rtl/dcfeb_rd_pkg.sv | 26 ++
 rtl/evt_occupancy_cnt.sv | 68 ++++++
 rtl/sample_readout_arbiter.sv | 149 ++++++++++++++
 tb/tb_sample_readout_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcfeb_rd_pkg.sv
// Shared types and defaults for the DCFEB sample-buffer readout arbiter.
// Holds the FSM state encoding, the grant-owner encoding and the default sizes.
package dcfeb_rd_pkg;

    localparam int EVT_DEPTH_DEF = 16;
    localparam int TMO_CYC_DEF   = 1024;
    localparam int TMO_W_DEF     = 11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT     = 2'b01,
        WAIT_DONE = 2'b10,
        GAP       = 2'b11
    } rd_state_e;

    typedef enum logic {
        OWN_DAQ  = 1'b0,
        OWN_JTAG = 1'b1
    } rd_owner_e;

    // States in which the transfer engine is told to move data
    function automatic logic is_xfer_state(input rd_state_e s);
        return (s == GRANT) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/evt_occupancy_cnt.sv
// Occupancy counter for L1A-matched events held in the sample buffer.
// Saturates at DEPTH; a write into a full buffer is reported as a drop.
module evt_occupancy_cnt
    import dcfeb_rd_pkg::*;
#(
    parameter int DEPTH = EVT_DEPTH_DEF,
    parameter int CNT_W = $clog2(EVT_DEPTH_DEF + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic             ovfl_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drop_q;
    logic             drop_d;
    logic             ovfl_q;
    logic             ovfl_d;
    logic             full_s;
    logic             dec_ok_s;

    assign full_s   = (cnt_q == CNT_W'(DEPTH));
    assign dec_ok_s = dec_i && (cnt_q != {CNT_W{1'b0}});

    // Next count; a read freeing a slot in the same cycle cancels the write
    always_comb begin
        cnt_d  = cnt_q;
        drop_d = 1'b0;
        ovfl_d = ovfl_q;
        if (inc_i && dec_ok_s) begin
            cnt_d = cnt_q;
        end else if (inc_i && full_s) begin
            drop_d = 1'b1;
            ovfl_d = 1'b1;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_ok_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count, drop pulse and sticky overflow registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= {CNT_W{1'b0}};
            drop_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            ovfl_q <= ovfl_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign drop_o  = drop_q;
    assign ovfl_o  = ovfl_q;

endmodule

// File: rtl/sample_readout_arbiter.sv
// Schedules sample-buffer readout, arbitrating the transfer engine between
// the DAQ trigger path and JTAG slow control, with a per-transfer watchdog.
module sample_readout_arbiter
    import dcfeb_rd_pkg::*;
#(
    parameter int EVT_DEPTH = EVT_DEPTH_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF,
    parameter int TMO_W     = TMO_W_DEF
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             L1A_MATCH,
    input  logic                             DAQ_EN,
    input  logic                             JTAG_MODE,
    input  logic                             JTAG_REQ,
    input  logic                             XFER_DONE,
    output logic                             XFER_RDY,
    output logic                             XFER_JTAG,
    output logic                             JTAG_BUSY,
    output logic [$clog2(EVT_DEPTH+1)-1:0]   EVT_CNT,
    output logic                             L1A_DROP,
    output logic                             OVFL,
    output logic                             TMO_ERR
);

    localparam int CNT_W = $clog2(EVT_DEPTH + 1);

    rd_state_e        state_q;
    rd_state_e        state_d;
    rd_owner_e        owner_q;
    rd_owner_e        owner_d;
    logic             pend_q;
    logic             pend_d;
    logic [TMO_W-1:0] wdog_q;
    logic [TMO_W-1:0] wdog_d;
    logic             tmo_err_q;
    logic             tmo_err_d;
    logic             xfer_rdy_q;
    logic             xfer_jtag_q;

    logic             done_s;
    logic             tmo_s;
    logic             dec_s;
    logic             empty_s;

    function automatic logic [TMO_W-1:0] wdog_inc(input logic [TMO_W-1:0] v);
        if (v == {TMO_W{1'b1}}) begin
            return v;
        end else begin
            return v + TMO_W'(1);
        end
    endfunction

    // Completion only counts once the engine has been granted and is running
    assign done_s = (state_q == WAIT_DONE) && XFER_DONE;
    assign tmo_s  = (state_q == WAIT_DONE) && !XFER_DONE &&
                    (wdog_q == TMO_W'(TMO_CYC - 1));
    assign dec_s  = done_s || tmo_s;

    evt_occupancy_cnt #(
        .DEPTH (EVT_DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .CLK     (CLK),
        .RST     (RST),
        .inc_i   (L1A_MATCH),
        .dec_i   (dec_s),
        .cnt_o   (EVT_CNT),
        .empty_o (empty_s),
        .drop_o  (L1A_DROP),
        .ovfl_o  (OVFL)
    );

    // Next-state, owner selection, watchdog and JTAG pending bit
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wdog_d    = {TMO_W{1'b0}};
        tmo_err_d = tmo_err_q | tmo_s;

        // A request arriving while the previous one retires is dropped
        if (dec_s && (owner_q == OWN_JTAG)) begin
            pend_d = 1'b0;
        end else if (JTAG_REQ) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            IDLE: begin
                if (!empty_s && JTAG_MODE && pend_q) begin
                    state_d = GRANT;
                    owner_d = OWN_JTAG;
                end else if (!empty_s && !JTAG_MODE && DAQ_EN) begin
                    state_d = GRANT;
                    owner_d = OWN_DAQ;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                state_d = WAIT_DONE;
                wdog_d  = {TMO_W{1'b0}};
            end
            WAIT_DONE: begin
                wdog_d = wdog_inc(wdog_q);
                if (dec_s) begin
                    state_d = GAP;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, control and registered engine-facing outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DAQ;
            pend_q      <= 1'b0;
            wdog_q      <= {TMO_W{1'b0}};
            tmo_err_q   <= 1'b0;
            xfer_rdy_q  <= 1'b0;
            xfer_jtag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            wdog_q      <= wdog_d;
            tmo_err_q   <= tmo_err_d;
            xfer_rdy_q  <= is_xfer_state(state_d);
            xfer_jtag_q <= is_xfer_state(state_d) && (owner_d == OWN_JTAG);
        end
    end

    assign XFER_RDY  = xfer_rdy_q;
    assign XFER_JTAG = xfer_jtag_q;
    assign JTAG_BUSY = pend_q || ((state_q == GRANT) && xfer_jtag_q);
    assign TMO_ERR   = tmo_err_q;

endmodule

// File: tb/tb_sample_readout_arbiter.sv
// Bench for sample_readout_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the readout rules.
module tb_sample_readout_arbiter;

    localparam int EVT_DEPTH = 16;
    localparam int TMO_CYC   = 1024;
    localparam int TMO_W     = 11;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       l1a = 1'b0;
    logic       daq = 1'b0;
    logic       jm = 1'b0;
    logic       jreq = 1'b0;
    logic       done = 1'b0;
    logic       XFER_RDY;
    logic       XFER_JTAG;
    logic       JTAG_BUSY;
    logic [4:0] EVT_CNT;
    logic       L1A_DROP;
    logic       OVFL;
    logic       TMO_ERR;

    int total = 0;
    int bad = 0;

    // Model: occupancy, pending request, sticky flags, transfer-in-progress
    // with its age in cycles, and cycles spent low since the last transfer.
    int m_cnt;
    int m_age;
    int m_low;
    bit m_pend;
    bit m_ovfl;
    bit m_tmo;
    bit m_rdy;
    bit m_jtag;
    bit m_drop;

    sample_readout_arbiter #(
        .EVT_DEPTH (EVT_DEPTH),
        .TMO_CYC   (TMO_CYC),
        .TMO_W     (TMO_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .L1A_MATCH (l1a),
        .DAQ_EN    (daq),
        .JTAG_MODE (jm),
        .JTAG_REQ  (jreq),
        .XFER_DONE (done),
        .XFER_RDY  (XFER_RDY),
        .XFER_JTAG (XFER_JTAG),
        .JTAG_BUSY (JTAG_BUSY),
        .EVT_CNT   (EVT_CNT),
        .L1A_DROP  (L1A_DROP),
        .OVFL      (OVFL),
        .TMO_ERR   (TMO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_age = 0; m_low = 2;
        m_pend = 1'b0; m_ovfl = 1'b0; m_tmo = 1'b0;
        m_rdy = 1'b0; m_jtag = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step();
        bit done_ok;
        bit to;
        bit fin;
        bit dec;
        bit grant_ok;
        int nxt;
        done_ok  = m_rdy && (m_age >= 2) && done;
        to       = m_rdy && (m_age == TMO_CYC + 1) && !done;
        fin      = done_ok || to;
        dec      = fin && (m_cnt > 0);
        grant_ok = !m_rdy && (m_low >= 2) && (m_cnt > 0) &&
                   ((jm && m_pend) || (!jm && daq));
        nxt = m_cnt + (l1a ? 1 : 0) - (dec ? 1 : 0);
        m_drop = 1'b0;
        if (nxt > EVT_DEPTH) begin
            nxt = EVT_DEPTH;
            m_drop = 1'b1;
            m_ovfl = 1'b1;
        end
        if (fin && m_jtag) m_pend = 1'b0;
        else if (jreq) m_pend = 1'b1;
        if (to) m_tmo = 1'b1;
        if (m_rdy) begin
            if (fin) begin
                m_rdy = 1'b0; m_jtag = 1'b0; m_low = 1;
            end else begin
                m_age++;
            end
        end else if (grant_ok) begin
            m_rdy = 1'b1; m_age = 1; m_jtag = jm;
        end else if (m_low < 2) begin
            m_low++;
        end
        m_cnt = nxt;
    endtask

    task automatic check_all();
        chk("evt_cnt",   32'(EVT_CNT),   32'(m_cnt));
        chk("xfer_rdy",  32'(XFER_RDY),  32'(m_rdy));
        chk("xfer_jtag", 32'(XFER_JTAG), 32'(m_jtag));
        chk("jtag_busy", 32'(JTAG_BUSY), 32'(m_pend || (m_rdy && m_age == 1 && m_jtag)));
        chk("l1a_drop",  32'(L1A_DROP),  32'(m_drop));
        chk("ovfl",      32'(OVFL),      32'(m_ovfl));
        chk("tmo_err",   32'(TMO_ERR),   32'(m_tmo));
    endtask

    // One clock: inputs already driven, model advances on the edge, then check
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
        l1a = 1'b0; jreq = 1'b0; done = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        l1a = 1'b0; jreq = 1'b0; done = 1'b0; daq = 1'b0; jm = 1'b0;
        #1;
        chk("rst_rdy",  32'(XFER_RDY),  32'd0);
        chk("rst_jtag", 32'(XFER_JTAG), 32'd0);
        chk("rst_busy", 32'(JTAG_BUSY), 32'd0);
        chk("rst_cnt",  32'(EVT_CNT),   32'd0);
        chk("rst_drop", 32'(L1A_DROP),  32'd0);
        chk("rst_ovfl", 32'(OVFL),      32'd0);
        chk("rst_tmo",  32'(TMO_ERR),   32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();

        // Single DAQ event
        daq = 1'b1; l1a = 1'b1;
        tick(); chk("s1_cnt", 32'(EVT_CNT), 32'd1);
        tick(); chk("s1_rdy", 32'(XFER_RDY), 32'd1);
        repeat (19) tick();
        done = 1'b1;
        tick(); chk("s1_cnt0", 32'(EVT_CNT), 32'd0); chk("s1_rdy0", 32'(XFER_RDY), 32'd0);
        repeat (5) tick();
        chk("s1_stay_low", 32'(XFER_RDY), 32'd0);

        // Overflow with DAQ disabled
        do_reset();
        for (int i = 0; i < 16; i++) begin
            l1a = 1'b1; tick();
        end
        chk("of_nodrop", 32'(L1A_DROP), 32'd0);
        l1a = 1'b1; tick();
        chk("of_drop", 32'(L1A_DROP), 32'd1);
        chk("of_cnt", 32'(EVT_CNT), 32'd16);
        chk("of_ovfl", 32'(OVFL), 32'd1);
        tick(); chk("of_drop_pulse", 32'(L1A_DROP), 32'd0);
        chk("of_no_rdy", 32'(XFER_RDY), 32'd0);

        // JTAG wins over DAQ
        do_reset();
        for (int i = 0; i < 3; i++) begin
            l1a = 1'b1; tick();
        end
        jm = 1'b1; daq = 1'b1; jreq = 1'b1;
        tick(); chk("arb_busy", 32'(JTAG_BUSY), 32'd1);
        tick(); chk("arb_rdy", 32'(XFER_RDY), 32'd1); chk("arb_jtag", 32'(XFER_JTAG), 32'd1);
        repeat (5) tick();
        done = 1'b1;
        tick(); chk("arb_busy0", 32'(JTAG_BUSY), 32'd0); chk("arb_cnt", 32'(EVT_CNT), 32'd2);
        repeat (10) tick();
        chk("arb_no_regrant", 32'(XFER_RDY), 32'd0);

        // Full buffer: write and completion in the same cycle, then watchdog
        do_reset();
        for (int i = 0; i < 16; i++) begin
            l1a = 1'b1; tick();
        end
        daq = 1'b1;
        repeat (4) tick();
        l1a = 1'b1; done = 1'b1;
        tick(); chk("sim_cnt", 32'(EVT_CNT), 32'd16); chk("sim_drop", 32'(L1A_DROP), 32'd0);
        tick(); chk("sim_drop2", 32'(L1A_DROP), 32'd0);
        tick(); chk("wd_grant", 32'(XFER_RDY), 32'd1);
        repeat (TMO_CYC) tick();
        chk("wd_not_yet", 32'(TMO_ERR), 32'd0);
        tick();
        chk("wd_tmo", 32'(TMO_ERR), 32'd1);
        chk("wd_cnt", 32'(EVT_CNT), 32'd15);
        chk("wd_gap", 32'(XFER_RDY), 32'd0);
        tick(); chk("wd_idle", 32'(XFER_RDY), 32'd0);
        tick(); chk("wd_regrant", 32'(XFER_RDY), 32'd1);

        // Reset in the middle of a transfer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            l1a = 1'b1; tick();
        end
        daq = 1'b1;
        repeat (4) tick();
        chk("mr_cnt", 32'(EVT_CNT), 32'd5);
        chk("mr_rdy", 32'(XFER_RDY), 32'd1);
        do_reset();
        tick(); chk("mr_after_cnt", 32'(EVT_CNT), 32'd0); chk("mr_after_rdy", 32'(XFER_RDY), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            l1a  = ($urandom_range(0, 3) == 0);
            jreq = ($urandom_range(0, 7) == 0);
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) daq = ~daq;
            if ($urandom_range(0, 79) == 0) jm = ~jm;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
